// File: rtl/fetch_unit.sv
// fetch_unit: fetches one instruction per PC via req/gnt/rvalid and hands it to the decoder with a valid/ready handshake
module fetch_unit #(
  parameter int DWIDTH = 16,
  parameter int IWIDTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DWIDTH-1:0] pc_in,
  output logic              pc_en,
  output logic [1:0]        pc_ctrl,
  output logic [7:0]        offset_addr,
  output logic              mem_req,
  output logic [DWIDTH-1:0] mem_addr,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [IWIDTH-1:0] mem_rdata,
  output logic              ir_valid,
  output logic [IWIDTH-1:0] ir_data,
  input  logic              ir_ready,
  input  logic              flush
);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_REQ   = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_HOLD  = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;
  logic [2:0]        state_q, state_d;
  logic              pc_en_q, ir_valid_q, ir_valid_d, capture;
  logic [IWIDTH-1:0] ir_data_q;
  logic [7:0]        offset_q;
  // A response that arrives together with a flush is dropped, so nothing is latched and the PC is not advanced
  assign capture = (state_q == S_WAIT) && mem_rvalid && !flush;
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = S_REQ;
      S_REQ:   state_d = mem_gnt ? (flush ? S_DRAIN : S_WAIT) : S_REQ;
      S_WAIT:  state_d = mem_rvalid ? (flush ? S_REQ : S_HOLD) : (flush ? S_DRAIN : S_WAIT);
      S_HOLD:  state_d = (ir_ready || flush) ? S_REQ : S_HOLD;
      S_DRAIN: state_d = mem_rvalid ? S_REQ : S_DRAIN;
      default: state_d = S_IDLE;
    endcase
  end
  assign ir_valid_d = capture ? 1'b1 :
                      ((state_q == S_HOLD) && (ir_ready || flush)) ? 1'b0 : ir_valid_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      pc_en_q    <= 1'b0;
      ir_valid_q <= 1'b0;
      ir_data_q  <= '0;
      offset_q   <= '0;
    end else begin
      state_q    <= state_d;
      pc_en_q    <= capture;
      ir_valid_q <= ir_valid_d;
      if (capture) begin
        ir_data_q <= mem_rdata;
        offset_q  <= mem_rdata[7:0];
      end
    end
  end
  assign mem_req     = (state_q == S_REQ);
  assign mem_addr    = mem_req ? pc_in : '0;
  assign pc_en       = pc_en_q;
  assign pc_ctrl     = pc_en_q ? 2'b01 : 2'b00;
  assign ir_valid    = ir_valid_q;
  assign ir_data     = ir_data_q;
  assign offset_addr = offset_q;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: per-cycle directed vectors against a fetch_unit driven by a bench-side PC register
module tb_fetch_unit;
  logic        clk = 0, rst = 1;
  logic [15:0] pc_in, mem_addr, mem_rdata = 0, ir_data;
  logic        pc_en, mem_req, mem_gnt = 0, mem_rvalid = 0, ir_valid, ir_ready = 0, flush = 0;
  logic [1:0]  pc_ctrl;
  logic [7:0]  offset_addr;
  logic [15:0] pc_q;
  int          errors = 0, checks = 0;
  typedef struct {
    logic        rst, gnt, rvalid, ready, flush;
    logic [15:0] rdata;
    logic        req;
    logic [15:0] addr;
    logic        pc_en, irv;
    logic [15:0] ird;
  } vec_t;
  vec_t tbl[$];
  fetch_unit #(.DWIDTH(16), .IWIDTH(16)) dut (
    .clk(clk), .rst(rst), .pc_in(pc_in), .pc_en(pc_en), .pc_ctrl(pc_ctrl),
    .offset_addr(offset_addr), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .ir_valid(ir_valid), .ir_data(ir_data), .ir_ready(ir_ready), .flush(flush)
  );
  always #5 clk = ~clk;
  always_ff @(posedge clk) pc_q <= rst ? 16'd0 : (pc_en && pc_ctrl == 2'b01) ? pc_q + 16'd1 : pc_q;
  assign pc_in = pc_q;
  function automatic vec_t mk(input logic r, g, v, rdy, f, input logic [15:0] rd,
                              input logic rq, input logic [15:0] a, input logic pe, iv,
                              input logic [15:0] id);
    vec_t x;
    x.rst = r; x.gnt = g; x.rvalid = v; x.ready = rdy; x.flush = f; x.rdata = rd;
    x.req = rq; x.addr = a; x.pc_en = pe; x.irv = iv; x.ird = id;
    return x;
  endfunction
  task automatic chk(input string name, input int n, input logic [31:0] act, exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h want %h", name, n, act, exp);
    end
  endtask
  task automatic step(input int n, input vec_t x);
    @(negedge clk);
    rst = x.rst; mem_gnt = x.gnt; mem_rvalid = x.rvalid; ir_ready = x.ready;
    flush = x.flush; mem_rdata = x.rdata;
    #1;
    chk("mem_req", n, 32'(mem_req), 32'(x.req));
    chk("mem_addr", n, 32'(mem_addr), 32'(x.addr));
    chk("pc_en", n, 32'(pc_en), 32'(x.pc_en));
    chk("pc_ctrl", n, 32'(pc_ctrl), x.pc_en ? 32'd1 : 32'd0);
    chk("ir_valid", n, 32'(ir_valid), 32'(x.irv));
    chk("ir_data", n, 32'(ir_data), 32'(x.ird));
    chk("offset_addr", n, 32'(offset_addr), 32'(x.ird[7:0]));
  endtask
  initial begin
    // reset, then zero-wait fetches of addresses 0..3 with ir_ready high
    tbl.push_back(mk(1,0,0,1,0,16'h0,    0,16'd0,0,0,16'h0));
    tbl.push_back(mk(0,0,0,1,0,16'h0,    0,16'd0,0,0,16'h0));
    tbl.push_back(mk(0,1,0,1,0,16'h0,    1,16'd0,0,0,16'h0));
    tbl.push_back(mk(0,0,1,1,0,16'hA5C3, 0,16'd0,0,0,16'h0));
    tbl.push_back(mk(0,0,0,1,0,16'h0,    0,16'd0,1,1,16'hA5C3));
    tbl.push_back(mk(0,1,0,1,0,16'h0,    1,16'd1,0,0,16'hA5C3));
    tbl.push_back(mk(0,0,1,1,0,16'h1111, 0,16'd0,0,0,16'hA5C3));
    tbl.push_back(mk(0,0,0,1,0,16'h0,    0,16'd0,1,1,16'h1111));
    tbl.push_back(mk(0,1,0,1,0,16'h0,    1,16'd2,0,0,16'h1111));
    tbl.push_back(mk(0,0,1,1,0,16'h2222, 0,16'd0,0,0,16'h1111));
    tbl.push_back(mk(0,0,0,1,0,16'h0,    0,16'd0,1,1,16'h2222));
    tbl.push_back(mk(0,1,0,1,0,16'h0,    1,16'd3,0,0,16'h2222));
    tbl.push_back(mk(0,0,1,1,0,16'h3333, 0,16'd0,0,0,16'h2222));
    tbl.push_back(mk(0,0,0,1,0,16'h0,    0,16'd0,1,1,16'h3333));
    // grant delayed 4 cycles, response delayed 3 cycles
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(0,0,0,1,0,16'h0,  1,16'd4,0,0,16'h3333));
    tbl.push_back(mk(0,1,0,1,0,16'h0,    1,16'd4,0,0,16'h3333));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(0,0,0,1,0,16'h0,  0,16'd0,0,0,16'h3333));
    tbl.push_back(mk(0,0,1,1,0,16'hBEEF, 0,16'd0,0,0,16'h3333));
    // decoder stalls for 5 cycles
    tbl.push_back(mk(0,0,0,0,0,16'h0,    0,16'd0,1,1,16'hBEEF));
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(0,0,1,0,0,16'h0,  0,16'd0,0,1,16'hBEEF));
    tbl.push_back(mk(0,0,0,1,0,16'h0,    0,16'd0,0,1,16'hBEEF));
    tbl.push_back(mk(0,0,0,1,0,16'h0,    1,16'd5,0,0,16'hBEEF));
    repeat (2) @(posedge clk);
    foreach (tbl[i]) step(i, tbl[i]);
    // flush in WAIT, response 2 cycles later is drained and REQ resumes at the same PC
    step(100, mk(0,1,0,0,0,16'h0,    1,16'd5,0,0,16'hBEEF));
    step(101, mk(0,0,0,0,1,16'h0,    0,16'd0,0,0,16'hBEEF));
    step(102, mk(0,1,0,0,0,16'h0,    0,16'd0,0,0,16'hBEEF));
    step(103, mk(0,0,1,0,0,16'hDEAD, 0,16'd0,0,0,16'hBEEF));
    step(104, mk(0,1,0,0,0,16'h0,    1,16'd5,0,0,16'hBEEF));
    // flush on the first HOLD cycle: pulse still completes, next REQ uses PC+1
    step(105, mk(0,0,1,0,0,16'h1234, 0,16'd0,0,0,16'hBEEF));
    step(106, mk(0,0,0,0,1,16'h0,    0,16'd0,1,1,16'h1234));
    step(107, mk(0,1,0,0,0,16'h0,    1,16'd6,0,0,16'h1234));
    // flush coinciding with the response: data dropped, no pc_en
    step(108, mk(0,0,1,0,1,16'h5555, 0,16'd0,0,0,16'h1234));
    step(109, mk(0,1,0,0,0,16'h0,    1,16'd6,0,0,16'h1234));
    // reset mid-transaction; the late response lands in IDLE/REQ and is ignored
    step(110, mk(1,0,0,0,0,16'h0,    0,16'd0,0,0,16'h1234));
    step(111, mk(0,0,1,0,0,16'h7777, 0,16'd0,0,0,16'h0));
    step(112, mk(0,0,1,0,0,16'h7777, 1,16'd0,0,0,16'h0));
    step(113, mk(0,0,0,0,0,16'h0,    1,16'd0,0,0,16'h0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
